// File: rtl/mure_pkg.sv
// Shared types and constants for the E-trace block retirement stage.
package mure_pkg;

    // Default field widths; module parameters must not exceed these.
    localparam int XLEN_DEF        = 64;
    localparam int IRETIRE_LEN_DEF = 32;
    localparam int ITYPE_LEN_DEF   = 3;
    localparam int CAUSE_LEN_DEF   = 5;
    localparam int PRIV_LEN_DEF    = 2;

    // Instruction classification as delivered by the itype detector.
    typedef enum logic [ITYPE_LEN_DEF-1:0] {
        ITYPE_STD      = 3'd0,
        ITYPE_EXC      = 3'd1,
        ITYPE_INT      = 3'd2,
        ITYPE_ERET     = 3'd3,
        ITYPE_NT_BR    = 3'd4,
        ITYPE_T_BR     = 3'd5,
        ITYPE_JUMP_UNI = 3'd6,
        ITYPE_JUMP_INF = 3'd7
    } itype_e;

    // One emitted block record, held in the output register.
    typedef struct packed {
        logic [XLEN_DEF-1:0]        iaddr;
        logic [IRETIRE_LEN_DEF-1:0] iretire;
        logic                       ilastsize;
        logic [ITYPE_LEN_DEF-1:0]   itype;
        logic [CAUSE_LEN_DEF-1:0]   cause;
        logic [XLEN_DEF-1:0]        tval;
        logic [PRIV_LEN_DEF-1:0]    priv;
    } block_rec_s;

    // Exceptions and interrupts close the block without retiring the instruction.
    function automatic logic is_trap(input logic [ITYPE_LEN_DEF-1:0] itype);
        return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
    endfunction

endpackage

// File: rtl/mure_block_retire.sv
// Accumulates contiguous itype-0 retirements into a block and emits one
// E-trace block record per block on exception, interrupt, eret, branch/jump,
// counter saturation or flush.
module mure_block_retire
    import mure_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int IRETIRE_LEN = 32,
    parameter int ITYPE_LEN   = 3,
    parameter int CAUSE_LEN   = 5,
    parameter int PRIV_LEN    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [XLEN-1:0]        pc_i,
    input  logic                   compressed_i,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic [CAUSE_LEN-1:0]   cause_i,
    input  logic [XLEN-1:0]        tval_i,
    input  logic [PRIV_LEN-1:0]    priv_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [XLEN-1:0]        iaddr_o,
    output logic [IRETIRE_LEN-1:0] iretire_o,
    output logic                   ilastsize_o,
    output logic [ITYPE_LEN-1:0]   itype_o,
    output logic [CAUSE_LEN-1:0]   cause_o,
    output logic [XLEN-1:0]        tval_o,
    output logic [PRIV_LEN-1:0]    priv_o
);

    // Counter arithmetic is one bit wider so cnt+size can never wrap.
    localparam logic [IRETIRE_LEN:0] MAX_CNT = {1'b0, {IRETIRE_LEN{1'b1}}};
    localparam logic [IRETIRE_LEN:0] SAT_CNT = MAX_CNT - (IRETIRE_LEN+1)'(1);

    logic                   blk_open_q, blk_open_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [IRETIRE_LEN-1:0] cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic [PRIV_LEN-1:0]    priv_q, priv_d;
    logic                   out_valid_q, out_valid_d;
    block_rec_s             rec_q, rec_d;

    logic                   slot_free;
    logic                   accept;
    logic                   emit;
    logic                   close;
    block_rec_s             new_rec;
    logic [XLEN-1:0]        start_addr;
    logic [IRETIRE_LEN:0]   cnt_base;
    logic [IRETIRE_LEN:0]   size_ext;
    logic [IRETIRE_LEN:0]   cnt_sum;

    // The output register is free unless a record is waiting on the encoder.
    assign slot_free  = !(out_valid_q && !ready_i);
    assign ready_o    = slot_free && !flush_i;
    assign accept     = valid_i && ready_o;
    assign start_addr = blk_open_q ? addr_q : pc_i;
    assign cnt_base   = blk_open_q ? {1'b0, cnt_q} : '0;
    assign size_ext   = compressed_i ? (IRETIRE_LEN+1)'(1) : (IRETIRE_LEN+1)'(2);
    assign cnt_sum    = cnt_base + size_ext;

    // Next-state for the open block and the output record.
    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block infers a latch.
        blk_open_d  = blk_open_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        priv_d      = priv_q;
        out_valid_d = out_valid_q && !ready_i;
        rec_d       = rec_q;
        emit        = 1'b0;
        close       = 1'b0;
        new_rec     = '0;

        if (flush_i) begin
            // A flush waits for the output slot so it cannot overwrite a pending record.
            if (slot_free && blk_open_q) begin
                emit              = 1'b1;
                close             = 1'b1;
                new_rec.iaddr     = XLEN_DEF'(addr_q);
                new_rec.iretire   = IRETIRE_LEN_DEF'(cnt_q);
                new_rec.ilastsize = last_q;
                new_rec.itype     = ITYPE_STD;
                new_rec.priv      = PRIV_LEN_DEF'(priv_q);
            end
        end else if (accept) begin
            new_rec.iaddr = XLEN_DEF'(start_addr);
            new_rec.priv  = PRIV_LEN_DEF'(priv_i);
            if (itype_i == '0) begin
                blk_open_d = 1'b1;
                addr_d     = start_addr;
                cnt_d      = cnt_sum[IRETIRE_LEN-1:0];
                last_d     = !compressed_i;
                priv_d     = priv_i;
                if (cnt_sum >= SAT_CNT) begin
                    emit              = 1'b1;
                    close             = 1'b1;
                    new_rec.iretire   = IRETIRE_LEN_DEF'(cnt_sum[IRETIRE_LEN-1:0]);
                    new_rec.ilastsize = !compressed_i;
                    new_rec.itype     = ITYPE_STD;
                end
            end else if (is_trap(ITYPE_LEN_DEF'(itype_i))) begin
                // The trapping instruction itself does not retire.
                emit              = 1'b1;
                close             = 1'b1;
                new_rec.iretire   = IRETIRE_LEN_DEF'(cnt_base[IRETIRE_LEN-1:0]);
                new_rec.ilastsize = blk_open_q && last_q;
                new_rec.itype     = ITYPE_LEN_DEF'(itype_i);
                new_rec.cause     = CAUSE_LEN_DEF'(cause_i);
                new_rec.tval      = XLEN_DEF'(tval_i);
            end else begin
                emit              = 1'b1;
                close             = 1'b1;
                new_rec.iretire   = IRETIRE_LEN_DEF'(cnt_sum[IRETIRE_LEN-1:0]);
                new_rec.ilastsize = !compressed_i;
                new_rec.itype     = ITYPE_LEN_DEF'(itype_i);
            end
        end

        if (close) begin
            blk_open_d = 1'b0;
            cnt_d      = '0;
            last_d     = 1'b0;
        end
        if (emit) begin
            out_valid_d = 1'b1;
            rec_d       = new_rec;
        end
    end

    // Block state and output register, synchronously reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking so every flop samples the pre-edge _d values regardless of statement order.
        if (rst_i) begin
            // NOTE: record payload is cleared as well, since the outputs must read 0 out of reset.
            blk_open_q  <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            priv_q      <= '0;
            out_valid_q <= 1'b0;
            rec_q       <= '0;
        end else begin
            blk_open_q  <= blk_open_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            priv_q      <= priv_d;
            out_valid_q <= out_valid_d;
            rec_q       <= rec_d;
        end
    end

    assign valid_o     = out_valid_q;
    assign iaddr_o     = rec_q.iaddr[XLEN-1:0];
    assign iretire_o   = rec_q.iretire[IRETIRE_LEN-1:0];
    assign ilastsize_o = rec_q.ilastsize;
    assign itype_o     = rec_q.itype[ITYPE_LEN-1:0];
    assign cause_o     = rec_q.cause[CAUSE_LEN-1:0];
    assign tval_o      = rec_q.tval[XLEN-1:0];
    assign priv_o      = rec_q.priv[PRIV_LEN-1:0];

endmodule
